fc_tx_scheduler: RTL and testbench

Packet-granular transmit scheduler in front of the FC framer's user TX port. It shares that port between two frame sources using round-robin arbitration, granting only at frame boundaries. Frame starts are gated by link state and a buffer-to-buffer (BB) credit counter, which is replenished by received R_RDY primitives. Its output feeds `fc_framer` usertx directly, and a small Avalon-MM window exposes credit state and counters.

---
 rtl/fc_sched_pkg.sv | 18 +
 rtl/fc_bb_credit.sv | 51 +++++
 rtl/fc_tx_scheduler.sv | 157 +++++++++++++++
 tb/tb_fc_tx_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_sched_pkg.sv
// Shared types and register map for the FC transmit scheduler.
package fc_sched;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2
  } sched_state_t;

  localparam logic [2:0] REG_CREDIT  = 3'd0;
  localparam logic [2:0] REG_FRAMES0 = 3'd1;
  localparam logic [2:0] REG_FRAMES1 = 3'd2;
  localparam logic [2:0] REG_ORPHAN  = 3'd3;
  localparam logic [2:0] REG_ABORT   = 3'd4;
  localparam logic [2:0] REG_OVF     = 3'd5;
  localparam logic [2:0] REG_STATUS  = 3'd6;

endpackage

// File: rtl/fc_bb_credit.sv
// Buffer-to-buffer credit counter: consumed by SOP transfers, returned by
// R_RDY, saturating at BB_CREDIT and reloaded while the link is down.
module fc_bb_credit #(
  parameter int BB_CREDIT = 8,
  parameter int CREDIT_W  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                consume,
  input  logic                r_rdy,
  input  logic                active,
  output logic [CREDIT_W-1:0] credit,
  output logic                nonzero,
  output logic [31:0]         ovf_cnt
);

  localparam logic [CREDIT_W-1:0] BB = CREDIT_W'(BB_CREDIT);

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [31:0]         ovf_q, ovf_d;

  // Next credit; a simultaneous consume and return cancel out.
  always_comb begin
    credit_d = credit_q;
    ovf_d    = ovf_q;
    if (!active) begin
      credit_d = BB;
    end else if (consume && !r_rdy) begin
      credit_d = credit_q - CREDIT_W'(1);
    end else if (r_rdy && !consume) begin
      if (credit_q >= BB) ovf_d = ovf_q + 32'd1;  // extra R_RDY is dropped
      else                credit_d = credit_q + CREDIT_W'(1);
    end
  end

  // Credit and overflow registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_q <= BB;
      ovf_q    <= '0;
    end else begin
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  assign credit  = credit_q;
  assign nonzero = (credit_q != '0);
  assign ovf_cnt = ovf_q;

endmodule

// File: rtl/fc_tx_scheduler.sv
// Frame-granular round-robin scheduler sharing the framer's user TX port
// between two sources, gated by link state and BB credit.
module fc_tx_scheduler import fc_sched::*; #(
  parameter int BB_CREDIT = 8,
  parameter int CREDIT_W  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                active,
  input  logic                r_rdy,
  input  logic [31:0]         in0_data,
  input  logic                in0_valid,
  input  logic                in0_startofpacket,
  input  logic                in0_endofpacket,
  output logic                in0_ready,
  input  logic [31:0]         in1_data,
  input  logic                in1_valid,
  input  logic                in1_startofpacket,
  input  logic                in1_endofpacket,
  output logic                in1_ready,
  output logic [31:0]         out_data,
  output logic                out_valid,
  output logic                out_startofpacket,
  output logic                out_endofpacket,
  input  logic                out_ready,
  output logic [CREDIT_W-1:0] credit,
  input  logic [2:0]          mm_address,
  input  logic                mm_read,
  output logic [31:0]         mm_readdata
);

  sched_state_t state_q;
  logic         grant_q, last_q;
  logic [31:0]  frames0_q, frames1_q, orphan_q, abort_q, rdata_q, rdata_d;
  logic [31:0]  ovf_cnt;
  logic         nonzero;

  logic [31:0]  g_data;
  logic         g_valid, g_sop, g_eop;
  logic         elig0, elig1, pick, orph0, orph1, beat_xfer, sop_xfer;

  assign g_data  = grant_q ? in1_data          : in0_data;
  assign g_valid = grant_q ? in1_valid         : in0_valid;
  assign g_sop   = grant_q ? in1_startofpacket : in0_startofpacket;
  assign g_eop   = grant_q ? in1_endofpacket   : in0_endofpacket;

  assign elig0 = in0_valid & in0_startofpacket & active & nonzero;
  assign elig1 = in1_valid & in1_startofpacket & active & nonzero;
  // On a tie the source that did not win last time gets the port.
  assign pick  = (elig0 & elig1) ? ~last_q : elig1;

  // Stray mid-frame beats seen while idle are swallowed; held off in reset
  // so every output is quiet while reset_n is low.
  assign orph0 = reset_n & (state_q == IDLE) & in0_valid & ~in0_startofpacket;
  assign orph1 = reset_n & (state_q == IDLE) & in1_valid & ~in1_startofpacket;

  assign beat_xfer = (state_q == XFER) & g_valid & out_ready;
  assign sop_xfer  = beat_xfer & g_sop;

  fc_bb_credit #(
    .BB_CREDIT (BB_CREDIT),
    .CREDIT_W  (CREDIT_W)
  ) u_credit (
    .clk     (clk),
    .reset_n (reset_n),
    .consume (sop_xfer),
    .r_rdy   (r_rdy),
    .active  (active),
    .credit  (credit),
    .nonzero (nonzero),
    .ovf_cnt (ovf_cnt)
  );

  // Zero-latency pass-through of the owning source; quiet outside XFER.
  always_comb begin
    out_data          = '0;
    out_valid         = 1'b0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    in0_ready         = orph0;
    in1_ready         = orph1;
    if (state_q == XFER) begin
      out_data          = g_data;
      out_valid         = g_valid;
      out_startofpacket = g_sop;
      out_endofpacket   = g_eop;
      if (grant_q) in1_ready = out_ready;
      else         in0_ready = out_ready;
    end else if (state_q == FLUSH) begin
      if (grant_q) in1_ready = 1'b1;
      else         in0_ready = 1'b1;
    end
  end

  // Arbitration FSM. A completed EOP wins over a same-cycle link drop so the
  // flush never eats into the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      abort_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (elig0 | elig1) begin
          grant_q <= pick;
          last_q  <= pick;
          state_q <= XFER;
        end
        XFER: if (beat_xfer & g_eop) begin
          state_q <= IDLE;
        end else if (!active) begin
          state_q <= FLUSH;
          abort_q <= abort_q + 32'd1;
        end
        FLUSH: if (g_valid & g_eop) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Frame and orphan statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames0_q <= '0;
      frames1_q <= '0;
      orphan_q  <= '0;
    end else begin
      if (sop_xfer && !grant_q) frames0_q <= frames0_q + 32'd1;
      if (sop_xfer &&  grant_q) frames1_q <= frames1_q + 32'd1;
      orphan_q <= orphan_q + {31'b0, orph0} + {31'b0, orph1};
    end
  end

  // Status register select.
  always_comb begin
    case (mm_address)
      REG_CREDIT:  rdata_d = 32'(credit);
      REG_FRAMES0: rdata_d = frames0_q;
      REG_FRAMES1: rdata_d = frames1_q;
      REG_ORPHAN:  rdata_d = orphan_q;
      REG_ABORT:   rdata_d = abort_q;
      REG_OVF:     rdata_d = ovf_cnt;
      REG_STATUS:  rdata_d = {29'b0, state_q, grant_q};
      default:     rdata_d = 32'hffff_ffff;
    endcase
  end

  // Registered read data, captured on mm_read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     rdata_q <= '0;
    else if (mm_read) rdata_q <= rdata_d;
  end

  assign mm_readdata = rdata_q;

endmodule

// File: tb/tb_fc_tx_scheduler.sv
// Bench for fc_tx_scheduler: directed frame scenarios with a per-cycle
// expectation table, randomized traffic against a behavioural model, a
// second instance with two credits for exhaustion, and async reset.
module tb_fc_tx_scheduler;

  localparam int BB = 8;

  typedef struct packed {logic [31:0] d; logic sop; logic eop;} beat_t;
  typedef struct packed {logic ordy; logic ov; logic sop; logic eop; logic r0; logic r1;} vec_t;
  typedef struct packed {logic [2:0] addr; logic [31:0] exp;} mmvec_t;

  logic        clk = 0, reset_n = 0, active = 0, r_rdy = 0, out_ready = 0;
  logic [31:0] in0_data = 0, in1_data = 0;
  logic        in0_valid = 0, in0_startofpacket = 0, in0_endofpacket = 0;
  logic        in1_valid = 0, in1_startofpacket = 0, in1_endofpacket = 0;
  logic        in0_ready, in1_ready, out_valid, out_startofpacket, out_endofpacket;
  logic [31:0] out_data, mm_readdata;
  logic [7:0]  credit;
  logic [2:0]  mm_address = 0;
  logic        mm_read = 0;

  logic        b_active = 0, b_r_rdy = 0, b_out_ready = 0;
  logic [31:0] b_in0_data = 0, b_out_data, b_mm_readdata;
  logic        b_in0_valid = 0, b_in0_sop = 0, b_in0_eop = 0, b_in0_ready, b_in1_ready;
  logic        b_out_valid, b_out_sop, b_out_eop;
  logic [7:0]  b_credit;

  always #5 clk = ~clk;

  fc_tx_scheduler #(.BB_CREDIT(BB), .CREDIT_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .active(active), .r_rdy(r_rdy),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_startofpacket(in0_startofpacket),
    .in0_endofpacket(in0_endofpacket), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_startofpacket(in1_startofpacket),
    .in1_endofpacket(in1_endofpacket), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket), .out_ready(out_ready), .credit(credit),
    .mm_address(mm_address), .mm_read(mm_read), .mm_readdata(mm_readdata));

  fc_tx_scheduler #(.BB_CREDIT(2), .CREDIT_W(8)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .active(b_active), .r_rdy(b_r_rdy),
    .in0_data(b_in0_data), .in0_valid(b_in0_valid), .in0_startofpacket(b_in0_sop),
    .in0_endofpacket(b_in0_eop), .in0_ready(b_in0_ready),
    .in1_data(32'd0), .in1_valid(1'b0), .in1_startofpacket(1'b0),
    .in1_endofpacket(1'b0), .in1_ready(b_in1_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_startofpacket(b_out_sop),
    .out_endofpacket(b_out_eop), .out_ready(b_out_ready), .credit(b_credit),
    .mm_address(3'd0), .mm_read(1'b0), .mm_readdata(b_mm_readdata));

  int checks = 0, errors = 0;
  beat_t q0[$], q1[$];
  // Behavioural model: who owns the port, whether it is being flushed, credit, stats.
  int  m_mode, m_own, m_last, m_credit, m_fr0, m_fr1, m_orph, m_abort, m_ovf;
  logic dir_ordy = 1, dir_rrdy = 0, dir_act = 1;
  bit   rand_en = 0, gen_en = 0;
  int   act_hold = 0;
  logic s_ov, s_sop, s_eop, s_r0, s_r1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input int s, input int n, input bit orphan);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d   = $urandom;
      b.sop = !orphan && (i == 0);
      b.eop = orphan ? 1'($urandom % 2) : (i == n - 1);
      if (s == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // One clock of traffic: drive, compare against the model, advance the model.
  task automatic step();
    beat_t h0, h1, hg;
    bit v0, v1, vg, e0, e1, x, sopx, r0e, r1e, ove;
    int pick;
    @(posedge clk); #1;
    if (rand_en) begin
      if (gen_en) begin
        if (q0.size() == 0 && $urandom % 3 == 0) push_frame(0, 1 + $urandom % 6, $urandom % 8 == 0);
        if (q1.size() == 0 && $urandom % 3 == 0) push_frame(1, 1 + $urandom % 6, $urandom % 8 == 0);
      end
      out_ready = ($urandom % 4) != 0;
      r_rdy     = ($urandom % 4) == 0;
      if (act_hold > 0) begin active = 0; act_hold--; end
      else begin active = 1; if ($urandom % 60 == 0) act_hold = 1 + $urandom % 4; end
    end else begin
      out_ready = dir_ordy; r_rdy = dir_rrdy; active = dir_act;
    end
    h0 = (q0.size() > 0) ? q0[0] : beat_t'('0);
    h1 = (q1.size() > 0) ? q1[0] : beat_t'('0);
    v0 = (q0.size() > 0) && (!rand_en || $urandom % 4 != 0);
    v1 = (q1.size() > 0) && (!rand_en || $urandom % 4 != 0);
    in0_valid = v0; in0_data = h0.d; in0_startofpacket = h0.sop; in0_endofpacket = h0.eop;
    in1_valid = v1; in1_data = h1.d; in1_startofpacket = h1.sop; in1_endofpacket = h1.eop;
    #4;
    hg = (m_own == 1) ? h1 : h0;
    vg = (m_own == 1) ? v1 : v0;
    r0e = 0; r1e = 0; ove = 0;
    if (m_mode == 0) begin
      r0e = v0 && !h0.sop; r1e = v1 && !h1.sop;
    end else if (m_mode == 1) begin
      ove = vg;
      if (m_own == 1) r1e = out_ready; else r0e = out_ready;
    end else begin
      if (m_own == 1) r1e = 1; else r0e = 1;
    end
    s_ov = out_valid; s_sop = out_startofpacket; s_eop = out_endofpacket;
    s_r0 = in0_ready; s_r1 = in1_ready;
    chk("out_valid", out_valid, ove);
    chk("out_sop", out_startofpacket, (m_mode == 1) && hg.sop);
    chk("out_eop", out_endofpacket, (m_mode == 1) && hg.eop);
    chk("out_data", out_data, (m_mode == 1) ? hg.d : 32'd0);
    chk("in0_ready", in0_ready, r0e);
    chk("in1_ready", in1_ready, r1e);
    chk("credit", credit, m_credit);
    sopx = 0;
    if (m_mode == 0) begin
      e0 = v0 && h0.sop && active && m_credit != 0;
      e1 = v1 && h1.sop && active && m_credit != 0;
      if (e0 || e1) begin
        pick = (e0 && e1) ? 1 - m_last : (e1 ? 1 : 0);
        m_own = pick; m_last = pick; m_mode = 1;
      end
      m_orph += int'(r0e) + int'(r1e);
    end else if (m_mode == 1) begin
      x = vg && out_ready;
      if (x && hg.sop) begin sopx = 1; if (m_own == 1) m_fr1++; else m_fr0++; end
      if (x && hg.eop) m_mode = 0;
      else if (!active) begin m_mode = 2; m_abort++; end
    end else begin
      if (vg && hg.eop) m_mode = 0;
    end
    if (!active) m_credit = BB;
    else begin
      m_credit = m_credit - int'(sopx) + int'(r_rdy);
      if (m_credit > BB) begin m_credit = BB; m_ovf++; end
    end
    if (v0 && r0e) void'(q0.pop_front());
    if (v1 && r1e) void'(q1.pop_front());
  endtask

  task automatic mm_rd(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1 mm_address = a; mm_read = 1;
    @(posedge clk); #1 mm_read = 0; #4 d = mm_readdata;
  endtask

  vec_t   tbl[12];
  mmvec_t mtbl[8];
  beat_t  qb[$];

  initial begin
    logic [31:0] rd;
    logic [1:0]  mm2;
    int n;
    bit done;
    // Per-cycle expectations for a tie between two 4-beat frames, with one stall.
    tbl = '{6'b100000, 6'b011000, 6'b111010, 6'b110010, 6'b110010, 6'b110110,
            6'b100000, 6'b111001, 6'b110001, 6'b110001, 6'b110101, 6'b100000};
    mtbl = '{{3'd0, 32'd8}, {3'd1, 32'd3}, {3'd2, 32'd1}, {3'd3, 32'd3},
             {3'd4, 32'd1}, {3'd5, 32'd1}, {3'd6, 32'd0}, {3'd7, 32'hffffffff}};
    m_mode = 0; m_own = 0; m_last = 1; m_credit = BB;
    m_fr0 = 0; m_fr1 = 0; m_orph = 0; m_abort = 0; m_ovf = 0;

    // Reset state
    active = 1; out_ready = 1;
    repeat (3) @(posedge clk);
    #5;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    chk("rst_credit", credit, BB);
    chk("rst_readdata", mm_readdata, 0);
    @(posedge clk); #1 reset_n = 1;

    // Tie: src0 first, one idle cycle, then src1
    push_frame(0, 4, 0); push_frame(1, 4, 0);
    for (int k = 0; k < 12; k++) begin
      dir_ordy = tbl[k].ordy;
      step();
      chk($sformatf("tie_ov[%0d]", k),  s_ov,  tbl[k].ov);
      chk($sformatf("tie_sop[%0d]", k), s_sop, tbl[k].sop);
      chk($sformatf("tie_eop[%0d]", k), s_eop, tbl[k].eop);
      chk($sformatf("tie_r0[%0d]", k),  s_r0,  tbl[k].r0);
      chk($sformatf("tie_r1[%0d]", k),  s_r1,  tbl[k].r1);
    end
    chk("tie_credit", credit, BB - 2);

    // Refill to full, then one R_RDY too many; then R_RDY alongside an SOP
    dir_ordy = 1; dir_rrdy = 1;
    repeat (3) step();
    dir_rrdy = 0; step();
    chk("ovf_credit", credit, BB);
    push_frame(0, 1, 0);
    step();
    dir_rrdy = 1; step();
    dir_rrdy = 0; step();
    chk("sop_rrdy_credit", credit, BB);

    // Link drop on the second beat of a 6-beat frame
    push_frame(0, 6, 0);
    step(); step();
    dir_act = 0; step();
    step();
    chk("drop_ov", s_ov, 0);
    chk("drop_r0", s_r0, 1);
    dir_act = 1;
    repeat (4) step();
    chk("drop_credit", credit, BB);

    // Three orphan beats from src1
    for (int i = 0; i < 3; i++) begin
      push_frame(1, 1, 1);
      step();
      chk($sformatf("orph_r1[%0d]", i), s_r1, 1);
      chk($sformatf("orph_ov[%0d]", i), s_ov, 0);
    end
    step();

    // Register map
    for (int i = 0; i < 8; i++) begin
      mm_rd(mtbl[i].addr, rd);
      chk($sformatf("mm_reg%0d", i), rd, mtbl[i].exp);
    end

    // Randomized traffic against the model
    rand_en = 1; gen_en = 1;
    repeat (3000) step();
    gen_en = 0; rand_en = 0; dir_ordy = 1; dir_act = 1; dir_rrdy = 1;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      done = (q0.size() == 0 && q1.size() == 0 && m_mode == 0);
    end
    chk("drain_done", done, 1);
    dir_rrdy = 0; step(); step();
    mm2 = 2'(m_mode);
    mm_rd(3'd0, rd); chk("rnd_credit", rd, m_credit);
    mm_rd(3'd1, rd); chk("rnd_frames0", rd, m_fr0);
    mm_rd(3'd2, rd); chk("rnd_frames1", rd, m_fr1);
    mm_rd(3'd3, rd); chk("rnd_orphan", rd, m_orph);
    mm_rd(3'd4, rd); chk("rnd_abort", rd, m_abort);
    mm_rd(3'd5, rd); chk("rnd_ovf", rd, m_ovf);
    mm_rd(3'd6, rd); chk("rnd_status", rd, {29'b0, mm2, 1'(m_own)});

    // Two-credit instance: third back-to-back frame is held until one R_RDY
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 2; i++) qb.push_back({32'hC000_0000 + 32'(f * 2 + i), i == 0, i == 1});
    b_active = 1; b_out_ready = 1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      b_in0_valid = qb.size() > 0;
      b_in0_data = qb[0].d; b_in0_sop = qb[0].sop; b_in0_eop = qb[0].eop;
      #4 if (b_in0_valid && b_in0_ready) void'(qb.pop_front());
    end
    chk("b_held_beats", qb.size(), 2);
    chk("b_credit_zero", b_credit, 0);
    chk("b_held_ready", b_in0_ready, 0);
    chk("b_held_ov", b_out_valid, 0);
    @(posedge clk); #1 b_r_rdy = 1; #4;
    n = 11;
    for (int i = 1; i <= 10 && n == 11; i++) begin
      @(posedge clk); #1 b_r_rdy = 0;
      b_in0_valid = qb.size() > 0;
      b_in0_data = qb[0].d; b_in0_sop = qb[0].sop; b_in0_eop = qb[0].eop;
      #4;
      if (b_out_valid && b_out_sop) n = i;
      if (b_in0_valid && b_in0_ready) void'(qb.pop_front());
    end
    chk("b_release_lat", n, 2);
    for (int i = 0; i < 10 && qb.size() > 0; i++) begin
      @(posedge clk); #1;
      b_in0_valid = 1;
      b_in0_data = qb[0].d; b_in0_sop = qb[0].sop; b_in0_eop = qb[0].eop;
      #4 if (b_in0_ready) void'(qb.pop_front());
    end
    @(posedge clk); #1 b_in0_valid = 0; #4;
    chk("b_drained", qb.size(), 0);
    chk("b_final_credit", b_credit, 0);

    // Asynchronous reset in the middle of a frame
    push_frame(0, 8, 0);
    step(); step(); step();
    @(posedge clk); #3;
    chk("pre_rst_ov", out_valid, 1);
    reset_n = 0; #1;
    chk("async_rst_ov", out_valid, 0);
    chk("async_rst_sop", out_startofpacket, 0);
    chk("async_rst_r0", in0_ready, 0);
    chk("async_rst_credit", credit, BB);
    chk("async_rst_rd", mm_readdata, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
